// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the tick-driven BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit that counts 0..MAX. It raises carry in the cycle where it
// wraps from MAX back to 0, so the next digit can chain off it directly.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry
);

  // Carry is combinational so that a whole chain of digits settles in one cycle.
  always_comb begin
    carry = inc && (value == MAX);
  end

  // Digit register: reset and clear dominate, then increment with wrap at MAX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= carry ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/tick_bcd_stopwatch.sv
// MM:SS stopwatch counting enfreq ticks, with an IDLE/RUN/PAUSE control FSM.
// Optional lap capture register is enabled by defining STOPWATCH_LAP_EN.
module tick_bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRE_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic [15:0] lap_bcd,
`endif
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        wrap
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  sw_state_t        state;
  sw_state_t        state_next;
  logic [PRE_W-1:0] pre;
  logic             count_en;
  logic             sec_adv;
  logic             c_sec_ones;
  logic             c_sec_tens;
  logic             c_min_ones;
  logic             c_min_tens;

  // A tick only matters in RUN; a second elapses on the last prescaler step.
  always_comb begin
    count_en = (state == RUN) && tick;
    sec_adv  = count_en && (pre == PRE_LAST);
  end

  // Next-state logic: clear wins over start_stop, which toggles run/pause.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, with running registered alongside so it tracks RUN exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  // Prescaler keeps its phase across pauses and restarts from 0 on clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (count_en) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
    end
  end

  bcd_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
    .clk(clk), .rst(rst), .inc(sec_adv),    .clr(clear),
    .value(sec_ones), .carry(c_sec_ones)
  );

  bcd_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
    .clk(clk), .rst(rst), .inc(c_sec_ones), .clr(clear),
    .value(sec_tens), .carry(c_sec_tens)
  );

  bcd_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
    .clk(clk), .rst(rst), .inc(c_sec_tens), .clr(clear),
    .value(min_ones), .carry(c_min_ones)
  );

  bcd_digit #(.MAX(BCD_MAX_TENS)) u_min_tens (
    .clk(clk), .rst(rst), .inc(c_min_ones), .clr(clear),
    .value(min_tens), .carry(c_min_tens)
  );

  // Wrap pulses for the single cycle after 59:59 rolls over to 00:00.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= c_min_tens && !clear;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap snapshot takes the digits before any same-cycle increment lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_bcd <= 16'h0000;
    end else if (clear) begin
      lap_bcd <= 16'h0000;
    end else if (lap && (state != IDLE)) begin
      lap_bcd <= {min_tens, min_ones, sec_tens, sec_ones};
    end
  end
`endif

endmodule

// File: tb/tb_tick_bcd_stopwatch.sv
// Self-checking bench for tick_bcd_stopwatch. Two instances (1 and 4 ticks
// per second) share the same stimulus and are each tracked by an
// elapsed-seconds model. Define STOPWATCH_LAP_EN to cover the lap feature.
module tb_tick_bcd_stopwatch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [3:0] so1, st1, mo1, mt1, so4, st4, mo4, mt4;
  logic       running1, wrap1, running4, wrap4;
  logic [15:0] bcd1, bcd4;
  logic [15:0] lap1, lap4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tick_bcd_stopwatch #(.TICKS_PER_SEC(1), .PRE_W(8)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_bcd(lap1),
`endif
    .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
    .running(running1), .wrap(wrap1)
  );

  tick_bcd_stopwatch #(.TICKS_PER_SEC(4), .PRE_W(8)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_bcd(lap4),
`endif
    .sec_ones(so4), .sec_tens(st4), .min_ones(mo4), .min_tens(mt4),
    .running(running4), .wrap(wrap4)
  );

`ifndef STOPWATCH_LAP_EN
  assign lap1 = 16'h0000;
  assign lap4 = 16'h0000;
`endif

  assign bcd1 = {mt1, mo1, st1, so1};
  assign bcd4 = {mt4, mo4, st4, so4};

  // Model: elapsed seconds as a plain integer, plus tick count within the second.
  int  tps[2] = '{1, 4};
  int  secs[2];
  int  pre[2];
  bit  active[2];
  bit  counting[2];
  bit  wrapExp[2];
  int  lapSecs[2];
  bit  primed = 1'b0;

  function automatic logic [15:0] expBcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10)};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      wrapExp[k] = 1'b0;
      if (!rst || clear) begin
        secs[k] = 0; pre[k] = 0; active[k] = 0; counting[k] = 0; lapSecs[k] = 0;
      end else begin
        if (lap && active[k]) lapSecs[k] = secs[k];
        if (counting[k] && tick) begin
          pre[k] = pre[k] + 1;
          if (pre[k] == tps[k]) begin
            pre[k] = 0;
            secs[k] = (secs[k] + 1) % 3600;
            wrapExp[k] = (secs[k] == 0);
          end
        end
        if (start_stop) begin
          counting[k] = !counting[k];
          active[k] = 1'b1;
        end
      end
    end
    if (!rst) primed = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (primed) begin
      checkOutput("dut1 digits", bcd1, expBcd(secs[0]));
      checkOutput("dut1 running", {15'd0, running1}, {15'd0, counting[0]});
      checkOutput("dut1 wrap", {15'd0, wrap1}, {15'd0, wrapExp[0]});
      checkOutput("dut4 digits", bcd4, expBcd(secs[1]));
      checkOutput("dut4 running", {15'd0, running4}, {15'd0, counting[1]});
      checkOutput("dut4 wrap", {15'd0, wrap4}, {15'd0, wrapExp[1]});
`ifdef STOPWATCH_LAP_EN
      checkOutput("dut1 lap", lap1, expBcd(lapSecs[0]));
      checkOutput("dut4 lap", lap4, expBcd(lapSecs[1]));
`endif
    end
  end

  // Drive one cycle of inputs, returning at the following falling edge.
  task automatic applyStimulus(input logic t, input logic ss, input logic cl, input logic lp);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(negedge clk);
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  initial begin
    // Reset held with ticks present, then free ticks without a start.
    rst = 1'b0;
    repeat (5) applyStimulus(1, 0, 0, 0);
    checkOutput("reset digits", bcd1, 16'h0000);
    checkOutput("reset running", {15'd0, running1}, 16'h0000);
    rst = 1'b1;
    repeat (5) applyStimulus(1, 0, 0, 0);
    checkOutput("idle ignores ticks", bcd1, 16'h0000);
    checkOutput("idle not running", {15'd0, running1}, 16'h0000);

    // Start and count ten seconds.
    applyStimulus(0, 1, 0, 0);
    repeat (10) applyStimulus(1, 0, 0, 0);
    checkOutput("ten seconds", bcd1, 16'h0010);
    checkOutput("ten seconds running", {15'd0, running1}, 16'h0001);
    checkOutput("dut4 after 10 ticks", bcd4, 16'h0002);

    // Pause ignores ticks, resume continues.
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (5) applyStimulus(1, 0, 0, 0);
    checkOutput("paused held", bcd1, 16'h0003);
    applyStimulus(0, 1, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 0);
    checkOutput("pause resume", bcd1, 16'h0005);

    // Four ticks per second: prescaler phase and clear on a tick.
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (7) applyStimulus(1, 0, 0, 0);
    checkOutput("dut4 seven ticks", bcd4, 16'h0001);
    applyStimulus(1, 0, 1, 0);
    checkOutput("dut4 clear on tick", bcd4, 16'h0000);
    checkOutput("dut4 clear idle", {15'd0, running4}, 16'h0000);
    applyStimulus(0, 1, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("dut4 prescaler zeroed", bcd4, 16'h0000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("dut4 fourth tick", bcd4, 16'h0001);

    // Same-cycle tick and start_stop in RUN, then in IDLE.
    checkOutput("dut1 before pause", bcd1, 16'h0004);
    applyStimulus(1, 1, 0, 0);
    checkOutput("run tick counted", bcd1, 16'h0005);
    checkOutput("run to pause", {15'd0, running1}, 16'h0000);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("idle tick dropped", bcd1, 16'h0000);
    checkOutput("idle to run", {15'd0, running1}, 16'h0001);

    // Lap at 00:42 then a one-cycle reset.
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (42) applyStimulus(1, 0, 0, 0);
    checkOutput("forty two", bcd1, 16'h0042);
    applyStimulus(0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    checkOutput("lap 0042", lap1, 16'h0042);
`endif
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    rst = 1'b1;
    checkOutput("mid reset digits", bcd1, 16'h0000);
    checkOutput("mid reset idle", {15'd0, running1}, 16'h0000);
`ifdef STOPWATCH_LAP_EN
    checkOutput("mid reset lap", lap1, 16'h0000);
`endif

    // Full rollover 59:59 -> 00:00, with a lap on the wrapping tick.
    applyStimulus(0, 1, 0, 0);
    repeat (3598) applyStimulus(1, 0, 0, 0);
    checkOutput("at 59:58", bcd1, 16'h5958);
    applyStimulus(1, 0, 0, 0);
    checkOutput("at 59:59", bcd1, 16'h5959);
    checkOutput("no early wrap", {15'd0, wrap1}, 16'h0000);
    applyStimulus(1, 0, 0, 1);
    checkOutput("rolled over", bcd1, 16'h0000);
    checkOutput("wrap pulse", {15'd0, wrap1}, 16'h0001);
`ifdef STOPWATCH_LAP_EN
    checkOutput("lap before wrap", lap1, 16'h5959);
`endif
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap one cycle", {15'd0, wrap1}, 16'h0000);
    checkOutput("still running", {15'd0, running1}, 16'h0001);
    checkOutput("dut4 at 15:00", bcd4, 16'h1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
